alu_result_accumulator: RTL
===========================

ALU_RESULT_ACCUMULATOR -- requirements
Module: alu_result_accumulator

Interface
REQ-001 The block SHALL sit directly downstream of the ALU stage and consume its 17-bit result Y and carry co.
REQ-002 Parameter SHALL be: ACC_W, default 24, accumulator width in bits; legal range ACC_W >= 17.
REQ-003 Parameter SHALL be: COUNT, default 4, number of ALU results summed per output; legal range COUNT >= 1.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 The ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  ALU result present on y_in/co_in
  in_ready  out  1  block accepts a beat this cycle
  y_in  in  17  ALU result Y, unsigned
  co_in  in  1  ALU carry-out for this beat
  clear  in  1  synchronous abort of the partial sum
  acc_out  out  ACC_W  accumulated sum
  ovf  out  1  saturation or carry seen in this sum
  out_valid  out  1  acc_out/ovf valid
  out_ready  in  1  downstream consumes the result
  count_out  out  clog2(COUNT+1)  beats accepted in the current sum

Function
REQ-006 The FSM SHALL have exactly two states: ACCUM and DONE.
REQ-007 A beat SHALL be accepted only on a rising edge where in_valid=1, in_ready=1 and clear=0.
REQ-008 in_ready SHALL be 1 only in ACCUM with rst_n=1; in_ready SHALL be 0 in DONE.
REQ-009 On accept: acc = acc + zero-extended y_in, and count_out = count_out + 1.
REQ-010 If the sum exceeds 2^ACC_W-1, acc SHALL saturate to all-ones and ovf SHALL be set.
REQ-011 Any accepted beat with co_in=1 SHALL set ovf; the sum itself SHALL be unaffected by co_in.
REQ-012 ovf SHALL be sticky for the current sum and cleared only on result consumption, clear, or reset.
REQ-013 On the COUNT-th accept, the FSM SHALL enter DONE; out_valid=1 SHALL appear the following cycle with acc_out including that beat (latency 1).
REQ-014 In DONE, out_valid, acc_out, ovf and count_out SHALL remain stable until out_valid=1 and out_ready=1 on the same edge.
REQ-015 On that handshake edge: state→ACCUM, acc=0, count_out=0, ovf=0, out_valid=0; in_ready=1 the next cycle (one bubble).
REQ-016 out_ready SHALL be ignored in ACCUM.
REQ-017 clear=1 in any state SHALL, on the edge: set state=ACCUM, acc=0, count_out=0, ovf=0, out_valid=0; any pending result is discarded.
REQ-018 clear=1 together with in_valid=1 SHALL drop that beat.
REQ-019 clear=1 together with the output handshake: clear wins, and the result counts as consumed.
REQ-020 count_out SHALL never exceed COUNT and SHALL wrap to 0 only via REQ-015/REQ-017.
REQ-021 acc_out SHALL expose the running sum in ACCUM; it is meaningful to downstream only while out_valid=1.
REQ-022 With COUNT=1, every accepted beat SHALL produce a result; the beat-to-beat period SHALL be 3 cycles with out_ready held at 1.

Reset
REQ-023 While rst_n=0, independent of clk: state=ACCUM, acc_out=0, count_out=0, ovf=0, out_valid=0, in_ready=0.
REQ-024 Reset asserted mid-sum or in DONE SHALL discard all partial or pending data; in_ready=1 from the first cycle after rst_n rises.

Verification (ACC_W=24, COUNT=4 unless stated)
REQ-025 Basic sum: beats y=15,1,3,7 with co=0, out_ready=1 → out_valid one cycle after the 4th accept, acc_out=26, ovf=0, count_out=4; next cycle count_out=0.
REQ-026 Back-pressure: after the result, out_ready=0 for 5 cycles while in_valid=1 → acc_out stays 26, in_ready=0, no beat accepted; handshake on cycle 6.
REQ-027 Saturation (ACC_W=17): beats 0x1FFFF,0x00001,0,0 → acc_out=0x1FFFF, ovf=1.
REQ-028 Carry flag: beats 5,2,3,2 with co_in=1 on beat 2 → acc_out=12, ovf=1; ovf=0 after the handshake.
REQ-029 Clear: accept 9,9, then clear=1 with in_valid=1, y=9 → count_out=0, beat dropped; then beats 1,1,1,1 → acc_out=4.
REQ-030 Reset: rst_n low after 2 beats and while in DONE → all outputs 0 immediately; in_ready=1 one cycle after release.

Source files
------------

// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator: sums COUNT consecutive ALU results into a saturating accumulator and hands the sum downstream
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   ALU result present on y_in/co_in
//   in_ready   block accepts a beat this cycle
//   y_in       17-bit unsigned ALU result
//   co_in      ALU carry-out for this beat
//   clear      synchronous abort of the partial sum, also discards a pending result
//   acc_out    accumulated sum (running sum while accumulating)
//   ovf        saturation or carry seen in this sum (sticky)
//   out_valid  acc_out/ovf/count_out valid
//   out_ready  downstream consumes the result
//   count_out  beats accepted in the current sum
module alu_result_accumulator #(
    parameter int ACC_W = 24,
    parameter int COUNT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [16:0]                y_in,
    input  logic                       co_in,
    input  logic                       clear,
    output logic [ACC_W-1:0]           acc_out,
    output logic                       ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(COUNT+1)-1:0] count_out
);
    localparam int CW = $clog2(COUNT+1);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t         state;
    logic           accept;
    logic           last;
    logic [ACC_W:0] sum;

    assign accept = in_valid && in_ready && !clear;
    assign last   = count_out == CW'(COUNT - 1);
    // One extra bit catches overflow past 2^ACC_W-1 for saturation
    assign sum    = {1'b0, acc_out} + (ACC_W + 1)'(y_in);

    // in_ready is registered: it drops on the final accept and returns one cycle
    // after the result is consumed, leaving a single bubble after each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc_out   <= '0;
            count_out <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc_out   <= '0;
            count_out <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (state == DONE) begin
            in_ready <= 1'b0;
            if (out_ready) begin
                state     <= ACCUM;
                acc_out   <= '0;
                count_out <= '0;
                ovf       <= 1'b0;
                out_valid <= 1'b0;
            end
        end else begin
            in_ready <= !(accept && last);
            if (accept) begin
                acc_out   <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                ovf       <= ovf | sum[ACC_W] | co_in;
                count_out <= count_out + CW'(1);
                if (last) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule
